// File: rtl/high_score_tracker_if.sv
// Bus between the game logic and the high-score tracker.
// The game side (master) drives the level, the running score and the clear
// request; the tracker (slave) returns the stored scores, the record pulse,
// the celebration flags and its FSM state for observation.
// dbg_state encoding: 0 = IDLE, 1 = PLAYING, 2 = COMPARE, 3 = CELEBRATE.
interface high_score_tracker_if #(
    parameter int SCORE_W = 14
);
    logic               game_in_progress;
    logic [SCORE_W-1:0] score;
    logic               clear_high;
    logic [SCORE_W-1:0] high_score;
    logic [SCORE_W-1:0] last_score;
    logic               new_record;
    logic               celebrating;
    logic               blink;
    logic [1:0]         dbg_state;

    modport master (
        output game_in_progress,
        output score,
        output clear_high,
        input  high_score,
        input  last_score,
        input  new_record,
        input  celebrating,
        input  blink,
        input  dbg_state
    );

    modport slave (
        input  game_in_progress,
        input  score,
        input  clear_high,
        output high_score,
        output last_score,
        output new_record,
        output celebrating,
        output blink,
        output dbg_state
    );
endinterface

// File: rtl/high_score_tracker.sv
// Session high-score tracker.
// Captures the clamped final score whenever a game ends, compares it against
// the stored best one cycle later, and on a strict improvement replaces the
// best, pulses new_record and runs a timed blink for the display mux.
// Handshake: there is no valid/ready pair; game_in_progress is a level whose
// rising edge starts a game and whose falling edge ends it, clear_high is a
// one-cycle request honoured on the next edge. All outputs are registered.
module high_score_tracker #(
    parameter int SCORE_W      = 14,
    parameter int MAX_SCORE    = 9999,
    parameter int CLK_PER_MS   = 50000,
    parameter int CELEBRATE_MS = 3000,
    parameter int BLINK_MS     = 250
) (
    input  logic                  clk,
    input  logic                  rst,
    high_score_tracker_if.slave   bus
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        PLAYING   = 2'd1,
        COMPARE   = 2'd2,
        CELEBRATE = 2'd3
    } state_t;

    localparam int PRE_W = (CLK_PER_MS > 1) ? $clog2(CLK_PER_MS) : 1;
    localparam int MS_W  = $clog2(CELEBRATE_MS + 1);
    localparam int BMS_W = (BLINK_MS > 1) ? $clog2(BLINK_MS) : 1;

    localparam logic [PRE_W-1:0]   PRE_LAST = PRE_W'(CLK_PER_MS - 1);
    localparam logic [MS_W-1:0]    MS_LAST  = MS_W'(CELEBRATE_MS - 1);
    localparam logic [BMS_W-1:0]   BMS_LAST = BMS_W'(BLINK_MS - 1);
    localparam logic [SCORE_W-1:0] MAX_S    = SCORE_W'(MAX_SCORE);

    state_t             state_q;
    logic               gip_q;
    logic [SCORE_W-1:0] high_q;
    logic [SCORE_W-1:0] last_q;
    logic [SCORE_W-1:0] last_d;
    logic               new_record_q;
    logic               celebrating_q;
    logic               blink_q;
    // pre_q: cycles within the current ms; ms_q: elapsed ms of the
    // celebration; bms_q: ms within the current blink half-period.
    logic [PRE_W-1:0]   pre_q;
    logic [MS_W-1:0]    ms_q;
    logic [BMS_W-1:0]   bms_q;
    logic               rise;
    logic               fall;

    // Edge detection against the registered copy of the level; gip_q resets
    // to 0 so a level already high at reset release reads as a rise.
    assign rise = bus.game_in_progress & ~gip_q;
    assign fall = ~bus.game_in_progress & gip_q;

    // Captured score saturates at the display limit.
    always_comb begin
        last_d = bus.score;
        if (bus.score > MAX_S) begin
            last_d = MAX_S;
        end
    end

    // Edge register for game_in_progress.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            gip_q <= 1'b0;
        end else begin
            gip_q <= bus.game_in_progress;
        end
    end

    // Main FSM with registered outputs and celebration timers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= IDLE;
            high_q        <= '0;
            last_q        <= '0;
            new_record_q  <= 1'b0;
            celebrating_q <= 1'b0;
            blink_q       <= 1'b0;
            pre_q         <= '0;
            ms_q          <= '0;
            bms_q         <= '0;
        end else begin
            // The record flag is a strict one-cycle pulse.
            new_record_q <= 1'b0;

            case (state_q)
                IDLE: begin
                    // A fall here is spurious and simply ignored.
                    if (rise) begin
                        state_q <= PLAYING;
                    end
                end

                PLAYING: begin
                    if (fall) begin
                        last_q  <= last_d;
                        state_q <= COMPARE;
                    end
                end

                COMPARE: begin
                    // A clear in this cycle discards any pending record.
                    if (bus.clear_high) begin
                        state_q <= IDLE;
                    end else if (last_q > high_q) begin
                        high_q        <= last_q;
                        new_record_q  <= 1'b1;
                        celebrating_q <= 1'b1;
                        blink_q       <= 1'b1;
                        pre_q         <= '0;
                        ms_q          <= '0;
                        bms_q         <= '0;
                        state_q       <= CELEBRATE;
                    end else begin
                        state_q <= IDLE;
                    end
                end

                CELEBRATE: begin
                    if (rise) begin
                        // New game aborts the show; the new best is kept.
                        state_q       <= PLAYING;
                        celebrating_q <= 1'b0;
                        blink_q       <= 1'b0;
                        pre_q         <= '0;
                        ms_q          <= '0;
                        bms_q         <= '0;
                    end else if (pre_q == PRE_LAST) begin
                        pre_q <= '0;
                        if (ms_q == MS_LAST) begin
                            // Final ms elapsed: end takes priority over a toggle.
                            state_q       <= IDLE;
                            celebrating_q <= 1'b0;
                            blink_q       <= 1'b0;
                            ms_q          <= '0;
                            bms_q         <= '0;
                        end else begin
                            ms_q <= ms_q + 1'b1;
                            if (bms_q == BMS_LAST) begin
                                bms_q   <= '0;
                                blink_q <= ~blink_q;
                            end else begin
                                bms_q <= bms_q + 1'b1;
                            end
                        end
                    end else begin
                        pre_q <= pre_q + 1'b1;
                    end
                end

                default: begin
                    state_q <= IDLE;
                end
            endcase

            // Clear overrides any update of the best score made above.
            if (bus.clear_high) begin
                high_q <= '0;
            end
        end
    end

    assign bus.high_score  = high_q;
    assign bus.last_score  = last_q;
    assign bus.new_record  = new_record_q;
    assign bus.celebrating = celebrating_q;
    assign bus.blink       = blink_q;
    assign bus.dbg_state   = state_q;

endmodule

// File: tb/tb_high_score_tracker.sv
// Bench for high_score_tracker with a fast timebase (4 cycles per ms,
// 3 ms celebration, 1 ms blink half-period). A game-level reference model
// tracks the expected outputs; directed steps cover the named scenarios and
// a randomized run of games follows.
module tb_high_score_tracker;

    localparam int SCORE_W      = 14;
    localparam int MAX_SCORE    = 9999;
    localparam int CLK_PER_MS   = 4;
    localparam int CELEBRATE_MS = 3;
    localparam int BLINK_MS     = 1;
    localparam int CEL_CYC      = CELEBRATE_MS * CLK_PER_MS;
    localparam int BLINK_CYC    = BLINK_MS * CLK_PER_MS;

    logic clk;
    logic rst;

    int checks = 0;
    int errors = 0;

    high_score_tracker_if #(.SCORE_W(SCORE_W)) bus ();

    high_score_tracker #(
        .SCORE_W     (SCORE_W),
        .MAX_SCORE   (MAX_SCORE),
        .CLK_PER_MS  (CLK_PER_MS),
        .CELEBRATE_MS(CELEBRATE_MS),
        .BLINK_MS    (BLINK_MS)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    // ---------------- clock ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- reference model ----------------
    // Game-level view: is a game running, is a result awaiting judgement,
    // and how many cycles a celebration has been running (-1 = none).
    int m_high;
    int m_last;
    int m_nr;
    bit m_gip;
    bit m_playing;
    bit m_pending;
    int m_cel_t;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_high = 0; m_last = 0; m_nr = 0;
            m_gip = 0; m_playing = 0; m_pending = 0; m_cel_t = -1;
        end else begin
            bit rise_e;
            bit fall_e;
            int s;
            rise_e = bus.game_in_progress && !m_gip;
            fall_e = !bus.game_in_progress && m_gip;
            m_gip  = bus.game_in_progress;
            m_nr   = 0;
            if (m_pending) begin
                m_pending = 0;
                if (!bus.clear_high && m_last > m_high) begin
                    m_high  = m_last;
                    m_nr    = 1;
                    m_cel_t = 0;
                end
            end else if (m_cel_t >= 0) begin
                if (rise_e) begin
                    m_cel_t   = -1;
                    m_playing = 1;
                end else begin
                    m_cel_t++;
                    if (m_cel_t >= CEL_CYC) m_cel_t = -1;
                end
            end else if (m_playing) begin
                if (fall_e) begin
                    s = int'(bus.score);
                    m_last    = (s > MAX_SCORE) ? MAX_SCORE : s;
                    m_playing = 0;
                    m_pending = 1;
                end
            end else if (rise_e) begin
                m_playing = 1;
            end
            if (bus.clear_high) m_high = 0;
        end
    end

    function automatic int exp_state();
        if (m_cel_t >= 0) return 3;
        if (m_pending)    return 2;
        if (m_playing)    return 1;
        return 0;
    endfunction

    function automatic int exp_blink();
        if (m_cel_t < 0) return 0;
        return ((m_cel_t / BLINK_CYC) % 2 == 0) ? 1 : 0;
    endfunction

    // ---------------- checking ----------------
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic cmp_model();
        chk("high_score",  32'(bus.high_score), m_high);
        chk("last_score",  32'(bus.last_score), m_last);
        chk("new_record",  32'(bus.new_record), m_nr);
        chk("celebrating", 32'(bus.celebrating), (m_cel_t >= 0) ? 1 : 0);
        chk("blink",       32'(bus.blink), exp_blink());
        chk("state",       32'(bus.dbg_state), exp_state());
    endtask

    // ---------------- driver ----------------
    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            @(negedge clk);
            cmp_model();
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int cel_sum;
        int nr_sum;
        int cel_log[14];
        int blk_log[14];
        int nr_log[14];
        int play_len;
        int idle_len;

        rst = 1'b0;
        bus.game_in_progress = 1'b0;
        bus.score = '0;
        bus.clear_high = 1'b0;

        // Reset state
        step(3);
        chk("reset_high", 32'(bus.high_score), 0);
        chk("reset_state", 32'(bus.dbg_state), 0);
        rst = 1'b1;
        step(2);

        // Record path: game 1 ends with 120
        bus.game_in_progress = 1'b1;
        step(1);
        chk("rise_to_playing", 32'(bus.dbg_state), 1);
        step(3);
        bus.score = 14'd120;
        bus.game_in_progress = 1'b0;
        step(1);
        chk("g1_last_N", 32'(bus.last_score), 120);
        chk("g1_state_compare", 32'(bus.dbg_state), 2);
        for (int k = 0; k < 14; k++) begin
            step(1);
            cel_log[k] = int'(bus.celebrating);
            blk_log[k] = int'(bus.blink);
            nr_log[k]  = int'(bus.new_record);
            if (k == 0) chk("g1_high_N1", 32'(bus.high_score), 120);
        end
        cel_sum = 0;
        nr_sum  = 0;
        for (int k = 0; k < 14; k++) begin
            cel_sum += cel_log[k];
            nr_sum  += nr_log[k];
        end
        chk("g1_celebrate_len", cel_sum, 12);
        chk("g1_new_record_pulses", nr_sum, 1);
        chk("g1_new_record_N1", nr_log[0], 1);
        chk("g1_blink_0", blk_log[0], 1);
        chk("g1_blink_4", blk_log[4], 0);
        chk("g1_blink_8", blk_log[8], 1);
        chk("g1_blink_12", blk_log[12], 0);
        chk("g1_cel_11", cel_log[11], 1);
        chk("g1_cel_12", cel_log[12], 0);

        // Non-record (80) then equal (120)
        bus.game_in_progress = 1'b1;
        step(3);
        bus.score = 14'd80;
        bus.game_in_progress = 1'b0;
        step(1);
        chk("g2_last", 32'(bus.last_score), 80);
        nr_sum = 0; cel_sum = 0;
        for (int k = 0; k < 5; k++) begin
            step(1);
            nr_sum += int'(bus.new_record);
            cel_sum += int'(bus.celebrating);
        end
        chk("g2_no_record", nr_sum, 0);
        chk("g2_no_celebrate", cel_sum, 0);
        chk("g2_high_kept", 32'(bus.high_score), 120);

        bus.game_in_progress = 1'b1;
        step(3);
        bus.score = 14'd120;
        bus.game_in_progress = 1'b0;
        step(1);
        chk("g3_last", 32'(bus.last_score), 120);
        nr_sum = 0; cel_sum = 0;
        for (int k = 0; k < 5; k++) begin
            step(1);
            nr_sum += int'(bus.new_record);
            cel_sum += int'(bus.celebrating);
        end
        chk("g3_equal_no_record", nr_sum, 0);
        chk("g3_equal_no_celebrate", cel_sum, 0);
        chk("g3_high_kept", 32'(bus.high_score), 120);

        // Clamp: 12000 saturates to 9999
        bus.game_in_progress = 1'b1;
        step(3);
        bus.score = 14'd12000;
        bus.game_in_progress = 1'b0;
        step(1);
        chk("clamp_last", 32'(bus.last_score), 9999);
        step(1);
        chk("clamp_high", 32'(bus.high_score), 9999);
        chk("clamp_record", 32'(bus.new_record), 1);

        // Abort: new game 5 cycles into the celebration
        step(4);
        bus.game_in_progress = 1'b1;
        step(1);
        chk("abort_state", 32'(bus.dbg_state), 1);
        chk("abort_celebrating", 32'(bus.celebrating), 0);
        chk("abort_blink", 32'(bus.blink), 0);
        chk("abort_high_kept", 32'(bus.high_score), 9999);

        // Clear while playing, then rebuild high=120
        bus.clear_high = 1'b1;
        step(1);
        bus.clear_high = 1'b0;
        chk("clear_playing_high", 32'(bus.high_score), 0);
        chk("clear_playing_state", 32'(bus.dbg_state), 1);
        bus.score = 14'd120;
        bus.game_in_progress = 1'b0;
        step(2);
        chk("rebuild_high", 32'(bus.high_score), 120);
        step(14);

        // Clear colliding with COMPARE: 300 vs 120
        bus.game_in_progress = 1'b1;
        step(3);
        bus.score = 14'd300;
        bus.game_in_progress = 1'b0;
        step(1);
        bus.clear_high = 1'b1;
        step(1);
        bus.clear_high = 1'b0;
        chk("collide_high", 32'(bus.high_score), 0);
        chk("collide_record", 32'(bus.new_record), 0);
        chk("collide_state", 32'(bus.dbg_state), 0);
        chk("collide_last", 32'(bus.last_score), 300);
        step(2);

        // Async reset mid-celebration, release with the level already high
        bus.game_in_progress = 1'b1;
        step(2);
        bus.score = 14'd500;
        bus.game_in_progress = 1'b0;
        step(2);
        chk("pre_reset_celebrating", 32'(bus.celebrating), 1);
        step(3);
        #2 rst = 1'b0;
        #1;
        chk("arst_high", 32'(bus.high_score), 0);
        chk("arst_last", 32'(bus.last_score), 0);
        chk("arst_celebrating", 32'(bus.celebrating), 0);
        chk("arst_blink", 32'(bus.blink), 0);
        chk("arst_new_record", 32'(bus.new_record), 0);
        chk("arst_state", 32'(bus.dbg_state), 0);
        bus.game_in_progress = 1'b1;
        @(negedge clk);
        rst = 1'b1;
        step(1);
        chk("arst_release_playing", 32'(bus.dbg_state), 1);

        // Randomized games checked cycle by cycle against the model
        for (int g = 0; g < 25; g++) begin
            bus.game_in_progress = 1'b1;
            play_len = $urandom_range(2, 8);
            for (int k = 0; k < play_len; k++) begin
                bus.clear_high = ($urandom_range(0, 15) == 0);
                step(1);
            end
            bus.clear_high = 1'b0;
            if ($urandom_range(0, 3) == 0)
                bus.score = SCORE_W'($urandom_range(9000, 16383));
            else
                bus.score = SCORE_W'($urandom_range(0, 9999));
            bus.game_in_progress = 1'b0;
            idle_len = $urandom_range(2, 20);
            for (int k = 0; k < idle_len; k++) begin
                bus.clear_high = ($urandom_range(0, 15) == 0);
                step(1);
            end
            bus.clear_high = 1'b0;
        end
        step(16);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
